// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned AddrW = 5;

  typedef logic [DataW-1:0] data_t;
  typedef logic [AddrW-1:0] addr_t;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  // Value loaded into entry idx by the post-reset sweep.
  function automatic logic [31:0] init_value(input int unsigned idx,
                                             input int unsigned sp_idx,
                                             input logic [31:0] sp_init);
    return (idx == sp_idx) ? sp_init : 32'd0;
  endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Write-port arbitration: per-address winner (highest port wins) and zero-register rejection.
module regfile_wr_arb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned Depth   = 2 ** ADDR_W
) (
  input  logic              en_i,
  input  logic [NUM_WR-1:0] wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i [NUM_WR],
  input  logic [DATA_W-1:0] wr_data_i [NUM_WR],
  output logic [Depth-1:0]  we_o,
  output logic [DATA_W-1:0] wdata_o   [Depth],
  output logic [NUM_WR-1:0] zero_rej_o
);

  always_comb begin
    we_o       = '0;
    wdata_o    = '{default: '0};
    zero_rej_o = '0;
    // Ascending scan so a later (higher-index) port overrides an earlier one.
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      if (en_i && wr_en_i[w]) begin
        if (ZERO_REG != 0 && wr_addr_i[w] == '0) begin
          zero_rej_o[w] = 1'b1;
        end else begin
          we_o[wr_addr_i[w]]    = 1'b1;
          wdata_o[wr_addr_i[w]] = wr_data_i[w];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads, write-first bypass and post-reset init sweep.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DataW,
  parameter int unsigned ADDR_W   = AddrW,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned SP_IDX   = 29,
  parameter int unsigned SP_INIT  = 252,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic                     ready,
  output logic [NUM_WR-1:0]        wr_err
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LastIdx = (ADDR_W + 1)'(Depth - 1);

  logic [DATA_W-1:0] mem_q [Depth];
  state_e            state_q, state_d;
  logic [ADDR_W:0]   init_cnt_q, init_cnt_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rd_data_q [NUM_RD];
  logic [DATA_W-1:0] rd_data_d [NUM_RD];
  logic [NUM_WR-1:0] wr_err_q;

  logic [ADDR_W-1:0] rd_addr_a [NUM_RD];
  logic [ADDR_W-1:0] wr_addr_a [NUM_WR];
  logic [DATA_W-1:0] wr_data_a [NUM_WR];
  logic [Depth-1:0]  we;
  logic [DATA_W-1:0] wdata [Depth];
  logic [NUM_WR-1:0] zero_rej;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign rd_addr_a[p]                 = rd_addr[p*ADDR_W +: ADDR_W];
    assign rd_data[p*DATA_W +: DATA_W]  = rd_data_q[p];
  end

  for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
    assign wr_addr_a[w] = wr_addr[w*ADDR_W +: ADDR_W];
    assign wr_data_a[w] = wr_data[w*DATA_W +: DATA_W];
  end

  regfile_wr_arb #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_WR  (NUM_WR),
    .ZERO_REG(ZERO_REG)
  ) u_wr_arb (
    .en_i      (state_q == StRun),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr_a),
    .wr_data_i (wr_data_a),
    .we_o      (we),
    .wdata_o   (wdata),
    .zero_rej_o(zero_rej)
  );

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ready_d    = ready_q;
    case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LastIdx) begin
          state_d = StRun;
          ready_d = 1'b1;
        end
      end
      StRun:   ;
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] v;
    ra        = '0;
    v         = '0;
    rd_data_d = '{default: '0};
    if (state_q == StRun) begin
      for (int unsigned p = 0; p < NUM_RD; p++) begin
        ra = rd_addr_a[p];
        v  = mem_q[ra];
        if (BYPASS != 0 && we[ra]) v = wdata[ra];
        if (ZERO_REG != 0 && ra == '0) v = '0;
        rd_data_d[p] = v;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
      rd_data_q  <= '{default: '0};
      wr_err_q   <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready_q    <= ready_d;
      rd_data_q  <= rd_data_d;
      wr_err_q   <= zero_rej;
    end
  end

  // Storage has no reset; the sweep that follows reset defines every entry.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      if (state_q == StInit) begin
        mem_q[init_cnt_q[ADDR_W-1:0]] <=
            DATA_W'(init_value(32'(init_cnt_q[ADDR_W-1:0]), SP_IDX, SP_INIT));
      end else begin
        for (int unsigned a = 0; a < Depth; a++) begin
          if (we[a]) mem_q[a] <= wdata[a];
        end
      end
    end
  end

  assign ready  = ready_q;
  assign wr_err = wr_err_q;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the single-write, dual-read CPU register file.
- Provides NUM_RD registered read ports, NUM_WR write ports with fixed priority, write-first bypass, and a hardwired zero register.
- Runs a sequential init sweep after reset that loads defined reset values, including the stack pointer.
- Sits between the decode stage (reads) and the writeback stage (writes) of the core datapath.

Parameters:
- DATA_W, 32, data width of each register.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports.
- SP_IDX, 29, index of the entry initialised to SP_INIT.
- SP_INIT, 252, init value for entry SP_IDX; all other entries init to 0.
- ZERO_REG, 1, when 1 entry 0 always reads 0 and writes to it are rejected.
- BYPASS, 1, when 1 a read of an address being written in the same cycle returns the new data.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- nrst  in  1  reset: synchronous, active-high.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  registered read data; same packing as rd_addr.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*ADDR_W  write addresses, packed.
- wr_data  in  NUM_WR*DATA_W  write data, packed.
- ready  out  1  high when the init sweep has finished and the file accepts traffic.
- wr_err  out  NUM_WR  one-cycle registered pulse per port when a write targets entry 0 with ZERO_REG=1.

Behaviour:
- FSM states: INIT, RUN.
- Reset (nrst=1 at a clk edge):
  - state<=INIT, init_cnt<=0, ready<=0.
  - All rd_data<=0, wr_err<=0.
  - Array contents are not touched during the reset cycle.
- INIT (nrst=0):
  - Each cycle writes entry init_cnt with SP_INIT if init_cnt==SP_IDX, else 0; then init_cnt++.
  - When init_cnt==DEPTH-1 is written, go to RUN and ready<=1 on the same edge.
  - The sweep therefore takes exactly DEPTH cycles after nrst falls.
  - wr_en is ignored and wr_err stays 0.
  - rd_data is held at 0.
- RUN writes:
  - Each port with wr_en=1 writes wr_data to wr_addr at the edge.
  - If two ports target the same address, the higher port index wins.
  - With ZERO_REG=1 and wr_addr==0: no write, and wr_err[w]<=1 for one cycle.
- RUN reads:
  - Latency 1: rd_data[p] at edge N+1 reflects rd_addr[p] sampled at edge N.
  - With BYPASS=1, a write at edge N to the same address returns that write's data (highest-index winning port).
  - With BYPASS=0, the read returns the pre-write contents.
  - Entry 0 with ZERO_REG=1 always reads 0, bypass included.
- Reset mid-operation: nrst=1 in RUN or INIT aborts immediately and restarts the sweep from 0 once nrst falls. Writes presented in the reset cycle are dropped.
- Arithmetic: init_cnt is ADDR_W+1 bits wide so the terminal compare does not alias. No other arithmetic.

Decomposition:
- Package regfile_pkg holds:
  - state enum {INIT, RUN};
  - default-width localparams (DATA_W, ADDR_W);
  - address/data typedefs;
  - function init_value(idx) returning SP_INIT or 0.
- One sub-module, regfile_wr_arb:
  - combinational per-address winner selection across write ports;
  - zero-register rejection;
  - feeds both the array write and the bypass mux.

Test Plan:
1. Pulse nrst=1 for 1 cycle, then 0 -> ready stays 0 for 32 cycles, rises on the 32nd edge. Then read addr 29 -> 252; read addrs 1 and 31 -> 0.
2. RUN: wr0 writes 0x11111110 to r5, r5 is read on the next cycle -> rd_data shows 0x11111110 one cycle after the read address is applied; other read port reading r6 -> 0.
3. Same cycle: wr0 writes r7=0xAAAA and wr1 writes r7=0xBBBB, rd0 reads r7 -> with BYPASS=1, next-cycle rd_data0=0xBBBB; a later read of r7 -> 0xBBBB.
4. wr0 writes r0=0xDEAD -> wr_err[0]=1 for exactly one cycle; a read of r0 -> 0.
5. Mid-sweep (cycle 10 of INIT) assert nrst -> ready=0, rd_data=0; after release a full 32-cycle sweep runs, and a value written before the reset (r5) reads 0 afterwards.
6. While in INIT, assert wr_en with r3=0x1234 -> ignored, wr_err=0; after ready, r3 reads 0.
